// File: rtl/fixed_point_iterative_butterfly_scaled.sv
// Radix-2 complex butterfly c = a + w*b, d = a - w*b with per-transaction /2 scaling,
// wrap-overflow flag, runtime twiddle mode and a Q-deep output queue.
module fixed_point_iterative_butterfly_scaled #(
  parameter int n = 32,
  parameter int d = 16,
  parameter int Q = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [2:0]   recv_mode,
  input  logic         recv_scale,
  input  logic [n-1:0] ar,
  input  logic [n-1:0] ac,
  input  logic [n-1:0] br,
  input  logic [n-1:0] bc,
  input  logic [n-1:0] wr,
  input  logic [n-1:0] wc,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] cr,
  output logic [n-1:0] cc,
  output logic [n-1:0] dr,
  output logic [n-1:0] dc,
  output logic         send_ovf
);

  localparam int PW = (Q > 1) ? $clog2(Q) : 1;
  localparam int CW = $clog2(Q + 1);
  localparam int MW = (n > 1) ? $clog2(n) : 1;
  localparam logic [MW-1:0] MUL_LAST = MW'(n - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(Q - 1);
  localparam logic [CW-1:0] QDEPTH   = CW'(Q);

  typedef enum logic {IDLE, MUL_WAIT} state_t;
  typedef struct packed {
    logic [n-1:0] cr, cc, dr, dc;
    logic         ovf;
  } entry_t;

  state_t state, state_next;

  logic fire, trivial, push, pop;
  logic [CW-1:0] count;
  logic [PW-1:0] head, tail;
  entry_t q_mem [Q];
  entry_t last_pop, push_e;

  logic [n-1:0] a_r_q, a_c_q;
  logic         scale_q;

  assign trivial  = (recv_mode >= 3'd1) && (recv_mode <= 3'd4);
  assign recv_rdy = (state == IDLE) && (count < QDEPTH);
  assign fire     = recv_val && recv_rdy;
  assign pop      = send_val && send_rdy;

  // Iterative signed shift-add complex multiplier: one multiplier bit per cycle for
  // all four partial products; the MSB step subtracts (two's-complement weight).
  logic                 mul_recv_val, mul_send_rdy, mul_busy, mul_done;
  logic [MW-1:0]        mul_cnt;
  logic [2*n-1:0]       mb_r, mb_c, acc_rr, acc_cc, acc_rc, acc_cr;
  logic [n-1:0]         mw_r, mw_c;
  logic [2*n-1:0]       mul_re_full, mul_im_full;
  logic [n-1:0]         mul_tr, mul_tc;
  logic                 unused_mul_bits;

  function automatic logic [2*n-1:0] pp(input logic [2*n-1:0] m, input logic b,
                                        input logic neg);
    return b ? (neg ? -m : m) : '0;
  endfunction

  assign mul_recv_val = fire && !trivial;
  assign mul_send_rdy = (state == MUL_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_busy <= 1'b0;
      mul_done <= 1'b0;
      mul_cnt  <= '0;
      mb_r     <= '0;
      mb_c     <= '0;
      mw_r     <= '0;
      mw_c     <= '0;
      acc_rr   <= '0;
      acc_cc   <= '0;
      acc_rc   <= '0;
      acc_cr   <= '0;
    end else if (mul_recv_val) begin
      mb_r     <= {{n{br[n-1]}}, br};
      mb_c     <= {{n{bc[n-1]}}, bc};
      mw_r     <= wr;
      mw_c     <= wc;
      acc_rr   <= '0;
      acc_cc   <= '0;
      acc_rc   <= '0;
      acc_cr   <= '0;
      mul_cnt  <= '0;
      mul_busy <= 1'b1;
    end else if (mul_busy) begin
      acc_rr  <= acc_rr + pp(mb_r, mw_r[0], mul_cnt == MUL_LAST);
      acc_cc  <= acc_cc + pp(mb_c, mw_c[0], mul_cnt == MUL_LAST);
      acc_rc  <= acc_rc + pp(mb_r, mw_c[0], mul_cnt == MUL_LAST);
      acc_cr  <= acc_cr + pp(mb_c, mw_r[0], mul_cnt == MUL_LAST);
      mb_r    <= mb_r << 1;
      mb_c    <= mb_c << 1;
      mw_r    <= mw_r >> 1;
      mw_c    <= mw_c >> 1;
      mul_cnt <= mul_cnt + 1'b1;
      if (mul_cnt == MUL_LAST) begin
        mul_busy <= 1'b0;
        mul_done <= 1'b1;
      end
    end else if (mul_done && mul_send_rdy) begin
      mul_done <= 1'b0;
    end
  end

  assign mul_re_full     = acc_rr - acc_cc;
  assign mul_im_full     = acc_rc + acc_cr;
  assign mul_tr          = mul_re_full[d+n-1:d];
  assign mul_tc          = mul_im_full[d+n-1:d];
  assign unused_mul_bits = ^{mul_re_full, mul_im_full};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      a_r_q   <= '0;
      a_c_q   <= '0;
      scale_q <= 1'b0;
    end else begin
      state <= state_next;
      if (mul_recv_val) begin
        a_r_q   <= ar;
        a_c_q   <= ac;
        scale_q <= recv_scale;
      end
    end
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (fire && trivial) push = 1'b1;
        if (fire && !trivial) state_next = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mul_done) begin
          push       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic [n-1:0] op_ar, op_ac, t_r, t_c;
  logic         op_scale;
  logic [n:0]   s_cr, s_cc, s_dr, s_dc;

  always_comb begin
    op_ar    = ar;
    op_ac    = ac;
    op_scale = recv_scale;
    t_r      = br;
    t_c      = bc;
    if (state == MUL_WAIT) begin
      op_ar    = a_r_q;
      op_ac    = a_c_q;
      op_scale = scale_q;
      t_r      = mul_tr;
      t_c      = mul_tc;
    end else begin
      case (recv_mode)
        3'd2:    begin t_r = -br; t_c = -bc; end
        3'd3:    begin t_r = -bc; t_c = br;  end
        3'd4:    begin t_r = bc;  t_c = -br; end
        default: begin t_r = br;  t_c = bc;  end
      endcase
    end
  end

  assign s_cr = {op_ar[n-1], op_ar} + {t_r[n-1], t_r};
  assign s_cc = {op_ac[n-1], op_ac} + {t_c[n-1], t_c};
  assign s_dr = {op_ar[n-1], op_ar} - {t_r[n-1], t_r};
  assign s_dc = {op_ac[n-1], op_ac} - {t_c[n-1], t_c};

  always_comb begin
    push_e.cr  = op_scale ? s_cr[n:1] : s_cr[n-1:0];
    push_e.cc  = op_scale ? s_cc[n:1] : s_cc[n-1:0];
    push_e.dr  = op_scale ? s_dr[n:1] : s_dr[n-1:0];
    push_e.dc  = op_scale ? s_dc[n:1] : s_dc[n-1:0];
    push_e.ovf = !op_scale && ((s_cr[n] ^ s_cr[n-1]) || (s_cc[n] ^ s_cc[n-1]) ||
                               (s_dr[n] ^ s_dr[n-1]) || (s_dc[n] ^ s_dc[n-1]));
  end

  always_ff @(posedge clk) begin
    if (push && !reset) q_mem[tail] <= push_e;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      last_pop <= '0;
    end else begin
      if (push) tail <= (tail == PTR_LAST) ? '0 : tail + 1'b1;
      if (pop) begin
        head     <= (head == PTR_LAST) ? '0 : head + 1'b1;
        last_pop <= q_mem[head];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An empty queue keeps presenting the most recently popped entry.
  assign send_val = (count != '0);
  assign {cr, cc, dr, dc, send_ovf} = send_val ? q_mem[head] : last_pop;

endmodule

// File: tb/tb_fixed_point_iterative_butterfly_scaled.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and a
// randomized scoreboard stream against a plain-arithmetic butterfly model.
module tb_fixed_point_iterative_butterfly_scaled;
  localparam int N  = 32;
  localparam int D  = 16;
  localparam int QD = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          recv_val = 1'b0;
  logic          recv_rdy;
  logic [2:0]    recv_mode = '0;
  logic          recv_scale = 1'b0;
  logic [N-1:0]  ar = '0, ac = '0, br = '0, bc = '0, wr = '0, wc = '0;
  logic          send_val;
  logic          send_rdy = 1'b0;
  logic [N-1:0]  cr, cc, dr, dc;
  logic          send_ovf;

  fixed_point_iterative_butterfly_scaled #(.n(N), .d(D), .Q(QD)) dut (
    .clk(clk), .reset(reset), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .recv_mode(recv_mode), .recv_scale(recv_scale),
    .ar(ar), .ac(ac), .br(br), .bc(bc), .wr(wr), .wc(wc),
    .send_val(send_val), .send_rdy(send_rdy),
    .cr(cr), .cc(cc), .dr(dr), .dc(dc), .send_ovf(send_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] cr, cc, dr, dc;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [2:0]   mode;
    logic         scale;
    logic [N-1:0] ar, ac, br, bc, wr, wc;
    res_t         exp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic res_t head();
    return {cr, cc, dr, dc, send_ovf};
  endfunction

  function automatic logic [N-1:0] fit(input longint s, input logic scale);
    return scale ? 32'(s >>> 1) : 32'(s);
  endfunction

  function automatic logic wraps(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Reference: complex butterfly on integers, product rescaled by 2^D.
  function automatic res_t model(input logic [2:0] mode, input logic scale,
                                 input int a_r, input int a_c, input int b_r,
                                 input int b_c, input int w_r, input int w_c);
    int tr, tc;
    longint re, im, s0, s1, s2, s3;
    res_t r;
    case (mode)
      3'd1: begin tr = b_r;  tc = b_c;  end
      3'd2: begin tr = -b_r; tc = -b_c; end
      3'd3: begin tr = -b_c; tc = b_r;  end
      3'd4: begin tr = b_c;  tc = -b_r; end
      default: begin
        re = longint'(b_r) * longint'(w_r) - longint'(b_c) * longint'(w_c);
        im = longint'(b_r) * longint'(w_c) + longint'(b_c) * longint'(w_r);
        tr = int'(re >>> D);
        tc = int'(im >>> D);
      end
    endcase
    s0 = longint'(a_r) + longint'(tr);
    s1 = longint'(a_c) + longint'(tc);
    s2 = longint'(a_r) - longint'(tr);
    s3 = longint'(a_c) - longint'(tc);
    r.cr  = fit(s0, scale);
    r.cc  = fit(s1, scale);
    r.dr  = fit(s2, scale);
    r.dc  = fit(s3, scale);
    r.ovf = !scale && (wraps(s0) || wraps(s1) || wraps(s2) || wraps(s3));
    return r;
  endfunction

  task automatic drive(input vec_t v);
    recv_mode = v.mode; recv_scale = v.scale;
    ar = v.ar; ac = v.ac; br = v.br; bc = v.bc; wr = v.wr; wc = v.wc;
  endtask

  // Issue one transaction from an empty, idle block; returns cycles until send_val.
  task automatic send_one(input vec_t v, output int lat);
    int waitc;
    @(negedge clk);
    drive(v);
    recv_val = 1'b1;
    waitc = 0;
    while (!recv_rdy && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("accept_rdy", recv_rdy, 1'b1);
    @(negedge clk);
    recv_val = 1'b0;
    lat = 1;
    while (!send_val && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vecs[11];
  res_t expq[$];
  int   popped[$];
  int   lat;
  logic got_acc, stale;
  vec_t rv;

  initial begin
    //          mode   sc    ar            ac            br            bc            wr            wc             cr            cc            dr            dc            ovf
    vecs[0]  = '{3'd1, 1'b0, 32'h00030000, 32'h0,        32'h00010000, 32'h0,        32'h0,        32'h0,        {32'h00040000, 32'h0,        32'h00020000, 32'h0,        1'b0}};
    vecs[1]  = '{3'd0, 1'b0, 32'h00010000, 32'h0,        32'h00020000, 32'h0,        32'h0,        32'h00010000, {32'h00010000, 32'h00020000, 32'h00010000, 32'hFFFE0000, 1'b0}};
    vecs[2]  = '{3'd3, 1'b0, 32'h00010000, 32'h0,        32'h00020000, 32'h0,        32'h0,        32'h0,        {32'h00010000, 32'h00020000, 32'h00010000, 32'hFFFE0000, 1'b0}};
    vecs[3]  = '{3'd1, 1'b0, 32'h7FFF0000, 32'h0,        32'h7FFF0000, 32'h0,        32'h0,        32'h0,        {32'hFFFE0000, 32'h0,        32'h0,        32'h0,        1'b1}};
    vecs[4]  = '{3'd1, 1'b1, 32'h7FFF0000, 32'h0,        32'h7FFF0000, 32'h0,        32'h0,        32'h0,        {32'h7FFF0000, 32'h0,        32'h0,        32'h0,        1'b0}};
    vecs[5]  = '{3'd5, 1'b0, 32'h00030000, 32'h0,        32'h00010000, 32'h0,        32'h00010000, 32'h0,        {32'h00040000, 32'h0,        32'h00020000, 32'h0,        1'b0}};
    vecs[6]  = '{3'd2, 1'b0, 32'h00030000, 32'h00010000, 32'h00010000, 32'h00020000, 32'h0,        32'h0,        {32'h00020000, 32'hFFFF0000, 32'h00040000, 32'h00030000, 1'b0}};
    vecs[7]  = '{3'd4, 1'b0, 32'h00030000, 32'h00010000, 32'h00010000, 32'h00020000, 32'h0,        32'h0,        {32'h00050000, 32'h0,        32'h00010000, 32'h00020000, 1'b0}};
    vecs[8]  = '{3'd1, 1'b1, 32'h0,        32'h0,        32'h00000001, 32'h0,        32'h0,        32'h0,        {32'h0,        32'h0,        32'hFFFFFFFF, 32'h0,        1'b0}};
    vecs[9]  = '{3'd0, 1'b0, 32'h0,        32'h0,        32'h00018000, 32'h00010000, 32'h00020000, 32'h0,        {32'h00030000, 32'h00020000, 32'hFFFD0000, 32'hFFFE0000, 1'b0}};
    vecs[10] = '{3'd1, 1'b0, 32'h0,        32'h80000000, 32'h0,        32'h80000000, 32'h0,        32'h0,        {32'h0,        32'h0,        32'h0,        32'h0,        1'b1}};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_send_val", send_val, 1'b0);
    chk("rst_recv_rdy", recv_rdy, 1'b1);
    chk("rst_head", head(), '0);

    foreach (vecs[i]) begin
      send_one(vecs[i], lat);
      chk($sformatf("vec%0d_val", i), send_val, 1'b1);
      chk($sformatf("vec%0d_res", i), head(), vecs[i].exp);
      if (vecs[i].mode >= 3'd1 && vecs[i].mode <= 3'd4)
        chk($sformatf("vec%0d_lat", i), lat, 1);
      else
        chk($sformatf("vec%0d_lat_gt1", i), (lat > 1 && lat < 200), 1'b1);
      send_rdy = 1'b1;
      @(negedge clk);
      send_rdy = 1'b0;
      chk($sformatf("vec%0d_empty", i), send_val, 1'b0);
      chk($sformatf("vec%0d_lastpop", i), head(), vecs[i].exp);
    end

    // Backpressure: two accepts fill Q=2, third waits until a pop frees space.
    rv = vecs[0];
    rv.br = '0;
    @(negedge clk);
    drive(rv);
    ar = 32'h00010000;
    recv_val = 1'b1;
    chk("bp_rdy_a", recv_rdy, 1'b1);
    @(negedge clk);
    chk("bp_rdy_b", recv_rdy, 1'b1);
    ar = 32'h00020000;
    @(negedge clk);
    ar = 32'h00030000;
    chk("bp_full", recv_rdy, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold", {send_val, cr, recv_rdy}, {1'b1, 32'h00010000, 1'b0});
    end
    send_rdy = 1'b1;
    popped.delete();
    popped.push_back(int'(cr));
    got_acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (got_acc) recv_val = 1'b0;
      if (send_val) popped.push_back(int'(cr));
      if (recv_val && recv_rdy) got_acc = 1'b1;
    end
    send_rdy = 1'b0;
    recv_val = 1'b0;
    chk("bp_third_acc", got_acc, 1'b1);
    chk("bp_pop_count", popped.size(), 3);
    for (int i = 0; i < popped.size() && i < 3; i++)
      chk($sformatf("bp_order%0d", i), popped[i], (i + 1) * 32'h00010000);

    // Reset while the multiplier is busy aborts the transaction.
    @(negedge clk);
    drive(vecs[1]);
    recv_val = 1'b1;
    chk("mw_accept", recv_rdy, 1'b1);
    @(negedge clk);
    recv_val = 1'b0;
    repeat (5) @(negedge clk);
    chk("mw_busy_rdy", recv_rdy, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    stale = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (send_val) stale = 1'b1;
    end
    chk("mw_no_stale", stale, 1'b0);
    chk("mw_rdy_after", recv_rdy, 1'b1);
    chk("mw_head_zero", head(), '0);
    send_one(vecs[1], lat);
    chk("mw_redo_res", head(), vecs[1].exp);
    send_rdy = 1'b1;
    @(negedge clk);
    send_rdy = 1'b0;

    // Random stream with random backpressure, scoreboarded in accept order.
    expq.delete();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      send_rdy = ($urandom_range(0, 3) != 0);
      recv_val = ($urandom_range(0, 2) != 0);
      rv.mode = 3'($urandom_range(0, 7));
      rv.scale = 1'($urandom_range(0, 1));
      rv.ar = $urandom; rv.ac = $urandom; rv.br = $urandom;
      rv.bc = $urandom; rv.wr = $urandom; rv.wc = $urandom;
      drive(rv);
      if (send_val && send_rdy) begin
        if (expq.size() == 0)
          chk("rnd_unexpected_pop", 1'b1, 1'b0);
        else
          chk("rnd_res", head(), expq.pop_front());
      end
      if (recv_val && recv_rdy)
        expq.push_back(model(rv.mode, rv.scale, rv.ar, rv.ac, rv.br, rv.bc, rv.wr, rv.wc));
    end
    @(negedge clk);
    recv_val = 1'b0;
    send_rdy = 1'b1;
    for (int i = 0; i < 200 && expq.size() != 0; i++) begin
      if (send_val) chk("rnd_drain_res", head(), expq.pop_front());
      @(negedge clk);
    end
    send_rdy = 1'b0;
    chk("rnd_drained", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
